i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter DEV_ADDR, default 7'h6A, is the 7-bit I2C device address (write byte 0xD4).
REQ-002 Parameter REG_AW, default 7, is the register pointer width (128 registers).
REQ-003 clock  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 scl_in  in  1  I2C SCL pin level, asynchronous.
REQ-006 sda_in  in  1  I2C SDA pin level, asynchronous.
REQ-007 sda_oe  out  1  1 = drive SDA low; 0 = release SDA (open-drain).
REQ-008 reg_wr_en  out  1  single-cycle write strobe.
REQ-009 reg_addr  out  REG_AW  current register pointer, used for both writes and reads.
REQ-010 reg_wr_data  out  8  write data, valid while reg_wr_en=1.
REQ-011 reg_rd_data  in  8  read data at reg_addr, one-clock latency from reg_addr.
REQ-012 busy  out  1  1 from an addressed START until the next STOP.

Function
REQ-013 The block SHALL synchronize scl_in and sda_in through 2 flops and then detect edges on the synchronized levels.
REQ-014 START (SDA falls while SCL high) SHALL enter ADDR from any state, including a repeated START.
REQ-015 STOP (SDA rises while SCL high) SHALL enter IDLE from any state, set sda_oe=0, and clear busy.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 Bit capture: sample SDA MSB-first on SCL rising edges; change sda_oe only on SCL falling edges.
REQ-018 ADDR, after 8 bits: if address = DEV_ADDR, assert sda_oe for one SCL period (ACK) and set busy; otherwise enter IGNORE with sda_oe=0 until START or STOP.
REQ-019 Addressed write (R/W=0): the first byte SHALL load the pointer from bits [REG_AW-1:0], ignore the upper bits, be ACKed, and issue no write strobe.
REQ-020 Each following write byte SHALL pulse reg_wr_en for exactly one clock at the SCL falling edge that starts WDATA_ACK, then be ACKed, then increment the pointer after the ACK.
REQ-021 The pointer SHALL wrap from 2^REG_AW-1 to 0.
REQ-022 A repeated START SHALL preserve the pointer.
REQ-023 A STOP between bytes SHALL preserve the pointer.
REQ-024 A partial byte (fewer than 8 bits before START/STOP) SHALL be discarded with no strobe and no pointer change.
REQ-025 SDA SHALL be released (sda_oe=0) on the SCL falling edge that ends each ACK slot.

Reset
REQ-026 While reset=0: state=IDLE, sda_oe=0, reg_wr_en=0, busy=0, pointer=0, bit counter=0, shift register=0, reg_wr_data=0.
REQ-027 Reset mid-transfer SHALL release SDA within 1 clock, and the block SHALL ignore the bus until the next START.

Configuration
REQ-028 Macro I2C_SLAVE_READ_EN: when defined, an addressed read (R/W=1) SHALL be ACKed and then transmit reg_rd_data MSB-first from the current pointer.
REQ-029 With I2C_SLAVE_READ_EN defined, reg_rd_data SHALL be latched at the ACK falling edge; each bit SHALL be driven on SCL falling edges (bit=0 means sda_oe=1).
REQ-030 With I2C_SLAVE_READ_EN defined, after 8 bits the block SHALL release SDA, sample the master ACK on SCL rising, and then:
- ACK: increment the pointer (with wrap) and continue.
- NACK: enter IGNORE.
REQ-031 Without I2C_SLAVE_READ_EN: a matching address with R/W=1 SHALL be NACKed and SHALL enter IGNORE; the read-path logic is absent and reg_rd_data is unused.

Verification
REQ-032 Write: START, 0xD4, 0x00, 0x11, 0x22, STOP -> 4 ACKs; strobes (addr 0x00, 0x11) and (0x01, 0x22); final pointer 0x02; busy low after STOP.
REQ-033 Wrong address: START, 0xD6, 0x05, STOP -> sda_oe never asserted, no strobe, pointer unchanged.
REQ-034 Wrap: START, 0xD4, 0x7F, 0xAA, 0xBB, STOP -> strobes (0x7F, 0xAA) and (0x00, 0xBB).
REQ-035 Read (READ_EN): START, 0xD4, 0x10, repeated START, 0xD5, read 2 bytes (master ACK, then NACK) with rd model mem[a]=a^0xFF -> SDA shows 0xEF then 0xEE, SDA released after the NACK.
REQ-036 Read (no READ_EN): START, 0xD5 -> ACK slot shows SDA high; the block ignores the bus until the next START.
REQ-037 Reset pulse during the 4th bit of a data byte -> sda_oe=0 next clock, no strobe, pointer=0; the next complete write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_regs_if.sv
// I2C slave register-bank bus bundle: pin side plus register-file side.
// The slave modport belongs to i2c_slave_regs; master is the bus/regfile environment.
interface i2c_slave_regs_if #(
    parameter int REG_AW = 7
) ();
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              reg_wr_en;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wr_data;
    logic [7:0]        reg_rd_data;
    logic              busy;

    modport slave (
        input  scl_in, sda_in, reg_rd_data,
        output sda_oe, reg_wr_en, reg_addr, reg_wr_data, busy
    );

    modport master (
        output scl_in, sda_in, reg_rd_data,
        input  sda_oe, reg_wr_en, reg_addr, reg_wr_data, busy
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave with a byte-wide register pointer; writes strobe a register port.
// Define I2C_SLAVE_READ_EN to add the read (R/W=1) transmit path.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h6A,
    parameter int         REG_AW   = 7
) (
    input logic           clock,
    input logic           reset,
    i2c_slave_regs_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [REG_AW-1:0] PtrOne = 1;
`ifdef I2C_SLAVE_READ_EN
    localparam bit RdEn = 1'b1;
`else
    localparam bit RdEn = 1'b0;
`endif

    // Sync stages are left unreset so a reset never fakes a bus edge
    logic [2:0] scl_sync_q;
    logic [2:0] sda_sync_q;

    state_t            state_q, state_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
`ifdef I2C_SLAVE_READ_EN
    logic              rw_q, rw_d;
`endif

    logic scl, sda, scl_rise, scl_fall, start, stop;
    logic byte_done, addr_ack;

    always_ff @(posedge clock) begin
        scl_sync_q <= {scl_sync_q[1:0], bus.scl_in};
        sda_sync_q <= {sda_sync_q[1:0], bus.sda_in};
    end

    assign scl       = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl & ~scl_sync_q[2];
    assign scl_fall  = ~scl & scl_sync_q[2];
    assign start     = scl & scl_sync_q[2] & sda_sync_q[2] & ~sda;
    assign stop      = scl & scl_sync_q[2] & ~sda_sync_q[2] & sda;
    assign byte_done = (cnt_q == 4'd8);
    assign addr_ack  = (shift_q[7:1] == DEV_ADDR) && (!shift_q[0] || RdEn);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
`ifdef I2C_SLAVE_READ_EN
            rw_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
`ifdef I2C_SLAVE_READ_EN
            rw_q      <= rw_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ADDR;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR: if (scl_fall && byte_done)
                    state_d = addr_ack ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) begin
                    state_d = PTR;
`ifdef I2C_SLAVE_READ_EN
                    if (rw_q) state_d = RDATA;
`endif
                end
                PTR:       if (scl_fall && byte_done) state_d = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_d = WDATA;
                WDATA:     if (scl_fall && byte_done) state_d = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_d = WDATA;
`ifdef I2C_SLAVE_READ_EN
                RDATA:     if (scl_fall && byte_done) state_d = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda) state_d = IGNORE;
                    else if (scl_fall)   state_d = RDATA;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
`ifdef I2C_SLAVE_READ_EN
        rw_d      = rw_q;
`endif
        if (start) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            shift_d  = '0;
        end else if (stop) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
            shift_d  = '0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && !byte_done) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            sda_oe_d = addr_ack;
                            busy_d   = busy_q | addr_ack;
`ifdef I2C_SLAVE_READ_EN
                            rw_d     = shift_q[0];
`endif
                        end else if (state_q == PTR) begin
                            ptr_d    = shift_q[REG_AW-1:0];
                            sda_oe_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_q;
                            sda_oe_d  = 1'b1;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = '0;
                    shift_d  = '0;
                    if (state_q == WDATA_ACK) ptr_d = ptr_q + PtrOne;
`ifdef I2C_SLAVE_READ_EN
                    if (state_q == ADDR_ACK && rw_q) begin
                        shift_d  = bus.reg_rd_data;
                        sda_oe_d = ~bus.reg_rd_data[7];
                    end
`endif
                end
`ifdef I2C_SLAVE_READ_EN
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !sda) begin
                        ptr_d = ptr_q + PtrOne;
                    end else if (scl_fall) begin
                        cnt_d    = '0;
                        shift_d  = bus.reg_rd_data;
                        sda_oe_d = ~bus.reg_rd_data[7];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.sda_oe      = sda_oe_q;
    assign bus.busy        = busy_q;
    assign bus.reg_addr    = ptr_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, open-drain SDA model,
// register read model mem[a]=a^0xFF and a write-strobe scoreboard.
module tb_i2c_slave_regs;
    localparam int Q = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    int rd_idx = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    i2c_slave_regs_if #(.REG_AW(7)) bus ();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    always @(posedge clk) bus.reg_rd_data <= {1'b0, bus.reg_addr} ^ 8'hFF;

    i2c_slave_regs #(.DEV_ADDR(7'h6A), .REG_AW(7)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.reg_wr_en) obs_q.push_back({bus.reg_addr, bus.reg_wr_data});
        if (bus.sda_oe) oe_cnt++;
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        wq(Q); sda_m = 1'b1;
        wq(Q); scl_m = 1'b1;
        wq(Q); sda_m = 1'b0;
        wq(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(Q); sda_m = 1'b0;
        wq(Q); scl_m = 1'b1;
        wq(Q); sda_m = 1'b1;
        wq(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            wq(Q); sda_m = b[i];
            wq(Q); scl_m = 1'b1;
            wq(2 * Q); scl_m = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        wq(Q); sda_m = 1'b1;
        wq(Q); scl_m = 1'b1;
        wq(Q); ack = bus.sda_in;
        wq(Q); scl_m = 1'b0;
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq(2 * Q); scl_m = 1'b1;
            wq(Q); d[i] = bus.sda_in;
            wq(Q); scl_m = 1'b0;
        end
        wq(Q); sda_m = ~m_ack;
        wq(Q); scl_m = 1'b1;
        wq(2 * Q); scl_m = 1'b0;
        wq(Q); sda_m = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        rst_n = 1'b0;
        wq(6);
        e = {bus.reg_addr, bus.reg_wr_data};
        checks++;
        if (e !== 15'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h, want 0000", e);
        end
        checks++;
        if ({bus.sda_oe, bus.reg_wr_en, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got oe/wr/busy=%b, want 000",
                     {bus.sda_oe, bus.reg_wr_en, bus.busy});
        end
        rst_n = 1'b1;
        wq(4);
    endtask

    task automatic test_write();
        logic [7:0] bytes [4] = '{8'hD4, 8'h00, 8'h11, 8'h22};
        logic ack;
        logic [14:0] e;
        exp_q.push_back({7'h00, 8'h11});
        exp_q.push_back({7'h01, 8'h22});
        i2c_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL write_ack%0d: got %b, want 0", i, ack);
            end
            if (i == 0) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL write_busy_set: got %b, want 1", bus.busy);
                end
            end
        end
        i2c_stop();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_clr: got %b, want 0", bus.busy);
        end
        checks++;
        if (bus.reg_addr !== 7'h02) begin
            errors++;
            $display("FAIL write_ptr: got %h, want 02", bus.reg_addr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL write_strobe: got none, want %h", e);
            end else begin
                if (obs_q[rd_idx] !== e) begin
                    errors++;
                    $display("FAIL write_strobe: got %h, want %h", obs_q[rd_idx], e);
                end
                rd_idx++;
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL write_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
        end
        rd_idx = obs_q.size();
    endtask

    task automatic test_wrong_addr();
        logic ack0, ack1;
        int oe0;
        logic [6:0] a0;
        oe0 = oe_cnt;
        a0 = bus.reg_addr;
        i2c_start();
        send_byte(8'hD6, ack0);
        send_byte(8'h05, ack1);
        i2c_stop();
        checks++;
        if ({ack0, ack1} !== 2'b11) begin
            errors++;
            $display("FAIL wrong_addr_nack: got %b, want 11", {ack0, ack1});
        end
        checks++;
        if (oe_cnt != oe0) begin
            errors++;
            $display("FAIL wrong_addr_oe: got %0d cycles, want 0", oe_cnt - oe0);
        end
        checks++;
        if (bus.reg_addr !== a0 || obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL wrong_addr_effect: got ptr %h strobes %0d, want ptr %h strobes 0",
                     bus.reg_addr, obs_q.size() - rd_idx, a0);
        end
        rd_idx = obs_q.size();
    endtask

    task automatic test_wrap();
        logic [7:0] bytes [4] = '{8'hD4, 8'h7F, 8'hAA, 8'hBB};
        logic ack;
        logic [14:0] e;
        exp_q.push_back({7'h7F, 8'hAA});
        exp_q.push_back({7'h00, 8'hBB});
        i2c_start();
        foreach (bytes[i]) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL wrap_ack%0d: got %b, want 0", i, ack);
            end
        end
        i2c_stop();
        checks++;
        if (bus.reg_addr !== 7'h01) begin
            errors++;
            $display("FAIL wrap_ptr: got %h, want 01", bus.reg_addr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL wrap_strobe: got none, want %h", e);
            end else begin
                if (obs_q[rd_idx] !== e) begin
                    errors++;
                    $display("FAIL wrap_strobe: got %h, want %h", obs_q[rd_idx], e);
                end
                rd_idx++;
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL wrap_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
        end
        rd_idx = obs_q.size();
    endtask

    task automatic test_partial_restart();
        logic ack;
        logic [14:0] e;
        exp_q.push_back({7'h20, 8'h55});
        exp_q.push_back({7'h40, 8'h66});
        i2c_start();
        send_byte(8'hD4, ack);
        send_byte(8'h20, ack);
        send_byte(8'h55, ack);
        send_bits(8'hC3, 5);
        i2c_start();
        send_byte(8'hD4, ack);
        checks++;
        if (bus.reg_addr !== 7'h21) begin
            errors++;
            $display("FAIL restart_ptr: got %h, want 21", bus.reg_addr);
        end
        send_byte(8'h40, ack);
        send_byte(8'h66, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL restart_ack: got %b, want 0", ack);
        end
        send_bits(8'h0F, 3);
        i2c_stop();
        checks++;
        if (bus.reg_addr !== 7'h41) begin
            errors++;
            $display("FAIL partial_ptr: got %h, want 41", bus.reg_addr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL partial_strobe: got none, want %h", e);
            end else begin
                if (obs_q[rd_idx] !== e) begin
                    errors++;
                    $display("FAIL partial_strobe: got %h, want %h", obs_q[rd_idx], e);
                end
                rd_idx++;
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL partial_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
        end
        rd_idx = obs_q.size();
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic test_read();
        logic ack;
        logic [7:0] d0, d1;
        i2c_start();
        send_byte(8'hD4, ack);
        send_byte(8'h10, ack);
        i2c_start();
        send_byte(8'hD5, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL read_addr_ack: got %b, want 0", ack);
        end
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        checks++;
        if ({d0, d1} !== 16'hEFEE) begin
            errors++;
            $display("FAIL read_data: got %h, want efee", {d0, d1});
        end
        wq(2 * Q);
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_release: got %b, want 0", bus.sda_oe);
        end
        i2c_stop();
        checks++;
        if (bus.reg_addr !== 7'h11 || obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL read_ptr: got %h strobes %0d, want 11 strobes 0",
                     bus.reg_addr, obs_q.size() - rd_idx);
        end
        rd_idx = obs_q.size();
    endtask
`else
    task automatic test_read();
        logic ack0, ack1;
        int oe0;
        logic [6:0] a0;
        oe0 = oe_cnt;
        a0 = bus.reg_addr;
        i2c_start();
        send_byte(8'hD5, ack0);
        send_byte(8'h00, ack1);
        i2c_stop();
        checks++;
        if ({ack0, ack1} !== 2'b11) begin
            errors++;
            $display("FAIL noread_nack: got %b, want 11", {ack0, ack1});
        end
        checks++;
        if (oe_cnt != oe0) begin
            errors++;
            $display("FAIL noread_oe: got %0d cycles, want 0", oe_cnt - oe0);
        end
        checks++;
        if (bus.reg_addr !== a0 || obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL noread_effect: got ptr %h strobes %0d, want ptr %h strobes 0",
                     bus.reg_addr, obs_q.size() - rd_idx, a0);
        end
        rd_idx = obs_q.size();
    endtask
`endif

    task automatic test_reset_mid();
        logic ack;
        logic [14:0] e;
        i2c_start();
        send_byte(8'hD4, ack);
        send_byte(8'h05, ack);
        send_bits(8'hB6, 3);
        wq(Q); sda_m = 1'b1;
        wq(Q); scl_m = 1'b1;
        wq(2);
        rst_n = 1'b0;
        wq(1);
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_oe: got %b, want 0", bus.sda_oe);
        end
        rst_n = 1'b1;
        wq(Q);
        checks++;
        if (bus.reg_addr !== 7'h00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got ptr %h busy %b, want 00 0",
                     bus.reg_addr, bus.busy);
        end
        scl_m = 1'b0;
        send_bits(8'h5A, 4);
        checks++;
        if (obs_q.size() != rd_idx) begin
            errors++;
            $display("FAIL rstmid_strobe: got %0d strobes, want 0", obs_q.size() - rd_idx);
        end
        exp_q.push_back({7'h03, 8'h44});
        i2c_start();
        send_byte(8'hD4, ack);
        send_byte(8'h03, ack);
        send_byte(8'h44, ack);
        i2c_stop();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ack: got %b, want 0", ack);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL rstmid_write: got none, want %h", e);
            end else begin
                if (obs_q[rd_idx] !== e) begin
                    errors++;
                    $display("FAIL rstmid_write: got %h, want %h", obs_q[rd_idx], e);
                end
                rd_idx++;
            end
        end
        checks++;
        if (obs_q.size() != rd_idx || bus.reg_addr !== 7'h04) begin
            errors++;
            $display("FAIL rstmid_after: got strobes %0d ptr %h, want 0 04",
                     obs_q.size() - rd_idx, bus.reg_addr);
        end
        rd_idx = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_wrap();
        test_partial_restart();
        test_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
